// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch front end of the pipelined CPU.
//   PC_STEP            : byte distance between sequential instructions
//   DEFAULT_RESET_VEC  : default PC loaded at reset
//   DEFAULT_EXC_VEC    : default exception entry address
//   pcg_state_t        : boot/run/halt state of the PC generator
//   pc_src_t           : which source supplies the next fetch PC
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_STEP = 4;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_4180;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pcg_state_t;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_REDIR,
        SRC_RAS,
        SRC_SEQ
    } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Return-address stack built as a circular buffer. A push onto a full stack
// overwrites the oldest entry, so the stack always holds the most recent
// RAS_DEPTH return addresses.
//   clk        : clock
//   rst        : asynchronous active-high reset, empties the stack
//   push       : push push_data
//   pop        : discard the top entry (ignored when empty)
//   push_data  : return address to push
//   top        : current top entry (only meaningful when count > 0)
//   count      : number of valid entries, 0..RAS_DEPTH
// ---------------------------------------------------------------------------
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(RAS_DEPTH):0]     count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic [PTR_W-1:0] w_next_slot;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_COUNT);
    // Call and return in the same cycle: the popped link is consumed and the
    // new link takes its place, so depth does not change. On an empty stack
    // there is nothing to replace and it behaves as a plain push.
    assign w_replace   = push && pop && !w_empty;
    // The pointer wraps naturally because RAS_DEPTH is a power of two.
    assign w_next_slot = r_top + PTR_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_replace) begin
            r_mem[r_top] <= push_data;
        end else if (push) begin
            r_top              <= w_next_slot;
            r_mem[w_next_slot] <= push_data;
            if (!w_full) begin
                r_count <= r_count + CNT_ONE;
            end
        end else if (pop && !w_empty) begin
            r_top   <= r_top - PTR_ONE;
            r_count <= r_count - CNT_ONE;
        end
    end

    assign top   = r_mem[r_top];
    assign count = r_count;

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Fetch program-counter generator. Each cycle it chooses the next fetch PC
// from exception entry, exception return, a resolved redirect, a RAS return
// prediction or sequential increment, honours hazard stalls, and runs a
// BOOT/RUN/HALTED state machine. WIDTH must be at least 8; RAS_DEPTH must be
// a power of two and at least 2.
//   clk, rst     : clock, asynchronous active-high reset
//   PC_IFWrite   : 1 advances the PC, 0 stalls it
//   exc, exc_pc  : exception request and faulting PC
//   eret         : return from exception to epc
//   redirect     : resolved taken branch/jump to redirect_pc
//   call_hint    : call decoded in ID at call_pc (pushes call_pc+4)
//   ret_hint     : return decoded in ID (pops the RAS)
//   halt, wake   : enter / leave HALTED
//   pc           : current fetch PC
//   pc_valid     : pc is a real fetch
//   epc          : saved exception PC
//   pred_ret     : next PC comes from the RAS (combinational)
//   ras_count    : valid RAS entries
// ---------------------------------------------------------------------------
module pc_gen
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEFAULT_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PC_IFWrite,
    input  logic                       exc,
    input  logic [WIDTH-1:0]           exc_pc,
    input  logic                       eret,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       call_hint,
    input  logic [WIDTH-1:0]           call_pc,
    input  logic                       ret_hint,
    input  logic                       halt,
    input  logic                       wake,
    output logic [WIDTH-1:0]           pc,
    output logic                       pc_valid,
    output logic [WIDTH-1:0]           epc,
    output logic                       pred_ret,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    pcg_state_t       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_pc_valid;

    pcg_state_t                 w_next_state;
    pc_src_t                    w_src;
    logic                       w_pc_we;
    logic                       w_epc_we;
    logic                       w_push;
    logic                       w_pop;
    logic [WIDTH-1:0]           w_target;
    logic [WIDTH-1:0]           w_next_pc;
    logic [WIDTH-1:0]           w_link;
    logic [WIDTH-1:0]           w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;
    logic                       w_ras_hit;

    assign w_ras_hit = ret_hint && (w_ras_count != '0);
    assign w_link    = (call_pc + STEP) & ~WIDTH'(3);

    // Control decode. Flush sources (exc, eret, redirect) win over a stall and
    // over halt; RAS traffic only happens on a normal, unstalled fetch so a
    // flushed or stalled call/return never disturbs the stack.
    always_comb begin
        w_next_state = r_state;
        w_src        = SRC_SEQ;
        w_pc_we      = 1'b0;
        w_epc_we     = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            BOOT: begin
                w_next_state = RUN;
            end
            RUN: begin
                if (exc) begin
                    w_src    = SRC_EXC;
                    w_pc_we  = 1'b1;
                    w_epc_we = 1'b1;
                end else if (eret) begin
                    w_src   = SRC_ERET;
                    w_pc_we = 1'b1;
                end else if (redirect) begin
                    w_src   = SRC_REDIR;
                    w_pc_we = 1'b1;
                end else if (halt) begin
                    w_next_state = HALTED;
                end else if (PC_IFWrite) begin
                    w_pc_we = 1'b1;
                    w_push  = call_hint;
                    w_pop   = ret_hint;
                    w_src   = w_ras_hit ? SRC_RAS : SRC_SEQ;
                end
            end
            HALTED: begin
                if (exc) begin
                    w_src        = SRC_EXC;
                    w_pc_we      = 1'b1;
                    w_epc_we     = 1'b1;
                    w_next_state = RUN;
                end else if (wake) begin
                    // The halted PC was already fetched, so resume after it.
                    w_src        = SRC_SEQ;
                    w_pc_we      = 1'b1;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = BOOT;
            end
        endcase
    end

    // Next-PC mux; every target is forced to word alignment.
    always_comb begin
        w_target = r_pc + STEP;
        case (w_src)
            SRC_EXC:   w_target = EXC_VEC;
            SRC_ERET:  w_target = r_epc;
            SRC_REDIR: w_target = redirect_pc;
            SRC_RAS:   w_target = w_ras_top;
            default:   w_target = r_pc + STEP;
        endcase
        w_next_pc = {w_target[WIDTH-1:2], 2'b00};
    end

    // PC, EPC and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_pc_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc_valid <= (w_next_state == RUN);
            if (w_pc_we) begin
                r_pc <= w_next_pc;
            end
            if (w_epc_we) begin
                r_epc <= exc_pc;
            end
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_link),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign epc       = r_epc;
    assign pred_ret  = w_pc_we && (w_src == SRC_RAS);
    assign ras_count = w_ras_count;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the pipelined CPU, the successor of the plain PC register. It holds the fetch PC and selects the next PC each cycle from reset, exception entry, exception return, resolved branch/jump redirects, a return-address-stack (RAS) prediction, or sequential increment. It honours hazard-unit stalls and runs a boot/run/halt state machine. It sits between the hazard unit, the ID/EX redirect logic and instruction memory.

## Interface
- `WIDTH`, 32: PC width in bits; must be ≥ 8.
- `RESET_VEC`, 32'h0000_3000: PC value loaded at reset.
- `EXC_VEC`, 32'h0000_4180: exception entry address.
- `RAS_DEPTH`, 4: number of RAS entries; power of two, ≥ 2.

- `clk` in 1: the single clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `PC_IFWrite` in 1: 1 advances the PC; 0 stalls it (driven by the hazard unit).
- `exc` in 1: exception request.
- `exc_pc` in WIDTH: PC of the faulting instruction.
- `eret` in 1: return from exception.
- `redirect` in 1: branch/jump resolved taken in EX.
- `redirect_pc` in WIDTH: target for `redirect`.
- `call_hint` in 1: ID decoded a call.
- `call_pc` in WIDTH: PC of the call in ID.
- `ret_hint` in 1: ID decoded a return.
- `halt` in 1: enter HALTED.
- `wake` in 1: leave HALTED.
- `pc` out WIDTH: current fetch PC.
- `pc_valid` out 1: `pc` is a real fetch.
- `epc` out WIDTH: saved exception PC.
- `pred_ret` out 1: this cycle's next PC comes from the RAS.
- `ras_count` out clog2(RAS_DEPTH)+1: number of valid RAS entries.

## Operation
- Reset values: `pc`=RESET_VEC, `epc`=0, `ras_count`=0, `pc_valid`=0, `pred_ret`=0, state=BOOT.
- States:
  - BOOT: `pc_valid`=0. Goes to RUN on the next clock edge.
  - RUN: `pc_valid`=1.
  - HALTED: `pc_valid`=0 and `pc` holds. Exit to RUN on `wake` or `exc`.
  - RUN→HALTED on `halt` when no redirect source is active. The PC does not advance on that edge.
- Next-PC priority, highest first:
  1. `exc`: EXC_VEC, and `epc`←`exc_pc`.
  2. `eret`: `epc`.
  3. `redirect`: `redirect_pc`.
  4. `ret_hint` with `ras_count`>0: RAS top, and `pred_ret`=1.
  5. Otherwise `pc`+4.
- Sources 1–3 override `PC_IFWrite`=0, because a flush wins over a stall. Sources 4–5 update only when `PC_IFWrite`=1.
- When `exc` and `eret` are both high, `exc` wins and `epc` takes `exc_pc`.
- All targets have bits [1:0] forced to 0. `pc`+4 wraps modulo 2^WIDTH; all-ones-minus-3 goes to 0.
- RAS updates are gated by `PC_IFWrite`=1 and suppressed when sources 1–3 are active:
  - Push on `call_hint` with value `call_pc`+4.
  - Pop on `ret_hint`.
  - Push when full: overwrite the oldest entry (circular); count stays RAS_DEPTH.
  - Pop when empty: no effect, and the next PC is sequential.
  - Push and pop together: replace the top; count is unchanged.
- `rst` mid-operation immediately forces all reset values, and the RAS empties.

## Timing
- All outputs are registered except `pred_ret`, which is combinational from the current inputs and RAS state.
- Next-PC selection takes effect at the following rising `clk`, so redirect latency is one cycle.
- `epc` updates on the same edge that `pc` takes EXC_VEC.
- After `rst` deasserts, the first edge goes BOOT→RUN with `pc` still at RESET_VEC. `pc_valid` rises after that edge.
- The stall has zero-cycle effect: while `PC_IFWrite`=0, `pc` holds on that edge.

## Structure
- Shared package `cpu_pkg`:
  - `PC_STEP` = 4.
  - Default RESET_VEC and EXC_VEC.
  - Enum `pcg_state_t` {BOOT, RUN, HALTED}.
  - Enum `pc_src_t` {SRC_EXC, SRC_ERET, SRC_REDIR, SRC_RAS, SRC_SEQ}.
- One sub-module, `ras_stack`, parametrised by WIDTH and RAS_DEPTH:
  - Circular buffer with top pointer and count.
  - Ports: push, pop, push_data, top, count.
  - Asynchronous reset.

## Test plan
- Reset and sequential fetch: assert `rst`, then release. Required: `pc`=0x3000 and `pc_valid`=0 for one cycle, then 0x3004, 0x3008 with `pc_valid`=1.
- Stall vs redirect: hold `PC_IFWrite`=0 for 3 cycles, so `pc` holds at 0x3008. Then, still stalled, raise `redirect` with `redirect_pc`=0x3103. Required: `pc`=0x3100 on the next edge.
- Exception and return: `exc` with `exc_pc`=0x3010 while `eret` is also high. Required: `pc`=0x4180 and `epc`=0x3010. A later `eret` gives `pc`=0x3010.
- RAS depth 4: push 5 calls at `call_pc` 0x3000, 0x3100, 0x3200, 0x3300, 0x3400. Required: `ras_count` saturates at 4. Five `ret_hint`s then predict 0x3404, 0x3304, 0x3204, 0x3104, followed by sequential with `pred_ret`=0.
- Simultaneous call/return, and wrap: push and pop in the same cycle leaves `ras_count` unchanged and top = new link. Separately, `pc`=0xFFFF_FFFC increments to 0x0000_0000.
- Halt/wake and async reset: `halt` freezes `pc` with `pc_valid`=0, and `wake` resumes at the next sequential PC. Asserting `rst` mid-cycle forces `pc`=0x3000 before the next edge.
